// File: rtl/bist_sched_pkg.sv
// Shared types and result codes for the BIST engine scheduler.
package bist_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_REPORT = 2'd2
   } state_e;

   localparam logic [15:0] RESULT_PASS    = 16'hFFFF;
   localparam logic [15:0] RESULT_TIMEOUT = 16'hFFFE;

endpackage

// File: rtl/bist_sched_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot winner, searching from last+1 upward with wrap.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int LW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0] req,
   input  logic [LW-1:0]   last,
   output logic [NREQ-1:0] gnt
);

   logic [LW-1:0] idx;

   always_comb begin
      gnt = '0;
      idx = '0;
      for (int i = 1; i <= NREQ; i++) begin
         idx = LW'((int'(last) + i) % NREQ);
         if (req[idx] && (gnt == '0)) gnt[idx] = 1'b1;
      end
   end

endmodule

// File: rtl/bist_sched.sv
// Shares one BIST engine among NREQ requesters with round-robin grants.
// Optional RUN watchdog enabled by defining BIST_SCHED_TIMEOUT_EN.
module bist_sched
   import bist_sched_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int SELW    = 2,
   parameter int TIMEOUT = 1024
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            abort,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] gnt,
   output logic [NREQ-1:0] done,
   output logic            pass,
   output logic [15:0]     fail_pc,
   output logic            busy,
   output logic            timeout,
   output logic            run_select,
   output logic [SELW-1:0] prog_sel,
   input  logic            eng_stop,
   input  logic            eng_error,
   input  logic [15:0]     eng_data,
   output logic [1:0]      state_dbg
);

   localparam int LW = $clog2(NREQ);

   localparam logic [1:0] IDLE   = ST_IDLE;
   localparam logic [1:0] RUN    = ST_RUN;
   localparam logic [1:0] REPORT = ST_REPORT;

   if (NREQ < 2 || NREQ > 8 || SELW < LW || TIMEOUT < 1) begin : g_bad_cfg
      $error("bist_sched: illegal parameter combination");
   end

   logic [1:0]      state;
   logic [LW-1:0]   last;
   logic [NREQ-1:0] arb_gnt;
   logic [LW-1:0]   win_idx;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req  (req),
      .last (last),
      .gnt  (arb_gnt)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) win_idx = LW'(i);
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

`ifdef BIST_SCHED_TIMEOUT_EN
   localparam int WDW = $clog2(TIMEOUT + 1);
   logic [WDW-1:0] wdog;
   logic           timeout_q;
   logic           wd_expire;
   // wdog holds the number of completed RUN cycles, so this is the TIMEOUT-th one
   assign wd_expire = (wdog == WDW'(TIMEOUT - 1));
   assign timeout   = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt        <= '0;
         done       <= '0;
         pass       <= 1'b0;
         fail_pc    <= '0;
         run_select <= 1'b0;
         prog_sel   <= '0;
         last       <= LW'(NREQ - 1);
`ifdef BIST_SCHED_TIMEOUT_EN
         wdog       <= '0;
         timeout_q  <= 1'b0;
`endif
      end else if (abort) begin
         // Cancel without reporting; last keeps the pre-abort priority order.
         state      <= IDLE;
         gnt        <= '0;
         done       <= '0;
         run_select <= 1'b0;
`ifdef BIST_SCHED_TIMEOUT_EN
         wdog       <= '0;
         timeout_q  <= 1'b0;
`endif
      end else begin
         done <= '0;
`ifdef BIST_SCHED_TIMEOUT_EN
         timeout_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (|arb_gnt) begin
                  gnt        <= arb_gnt;
                  prog_sel   <= SELW'(win_idx);
                  run_select <= 1'b1;
                  state      <= RUN;
`ifdef BIST_SCHED_TIMEOUT_EN
                  wdog       <= '0;
`endif
               end
            end
            RUN: begin
               if (eng_stop) begin
                  pass       <= !eng_error;
                  fail_pc    <= eng_data;
                  done       <= gnt;
                  run_select <= 1'b0;
                  state      <= REPORT;
               end
`ifdef BIST_SCHED_TIMEOUT_EN
               else if (wd_expire) begin
                  pass       <= 1'b0;
                  fail_pc    <= RESULT_TIMEOUT;
                  done       <= gnt;
                  run_select <= 1'b0;
                  timeout_q  <= 1'b1;
                  state      <= REPORT;
               end else begin
                  wdog <= wdog + 1'b1;
               end
`endif
            end
            REPORT: begin
               gnt   <= '0;
               last  <= prog_sel[LW-1:0];
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bist_sched.sv
// Directed bench for bist_sched: stimulus pushes expected reports, a monitor pops them on done.
module tb_bist_sched;

   localparam int NREQ = 4;
   localparam int SELW = 2;
   localparam int EW   = NREQ + 1 + 16 + 1;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            abort = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] done;
   logic            pass;
   logic [15:0]     fail_pc;
   logic            busy;
   logic            timeout;
   logic            run_select;
   logic [SELW-1:0] prog_sel;
   logic            eng_stop = 1'b0;
   logic            eng_error = 1'b0;
   logic [15:0]     eng_data = '0;
   logic [1:0]      state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] exp_e;

   bist_sched #(.NREQ(NREQ), .SELW(SELW), .TIMEOUT(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .abort      (abort),
      .req        (req),
      .gnt        (gnt),
      .done       (done),
      .pass       (pass),
      .fail_pc    (fail_pc),
      .busy       (busy),
      .timeout    (timeout),
      .run_select (run_select),
      .prog_sel   (prog_sel),
      .eng_stop   (eng_stop),
      .eng_error  (eng_error),
      .eng_data   (eng_data),
      .state_dbg  (state_dbg)
   );

   // clock / safety limit
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 500000");
      $fatal(1, "global timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // monitor: every done pulse must match the oldest expected report
   always @(negedge clk) begin
      if (rst_n && done !== '0) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: got done=%b expected no report", done);
         end else begin
            exp_e = exp_q.pop_front();
            chk("report_result", {28'd0, done, pass, fail_pc, timeout} >> 0, {10'd0, exp_e});
         end
         chk("report_run_select", {31'd0, run_select}, 32'd0);
      end else if (rst_n && timeout !== 1'b0) begin
         chk("stray_timeout", {31'd0, timeout}, 32'd0);
      end
   end

   // driver tasks
   task automatic wait_grant(input int widx, input int exp_lat, input string name);
      int n = 0;
      bit got = 0;
      while (!got && n < 20) begin
         @(negedge clk);
         n++;
         if (gnt !== '0) got = 1;
      end
      chk({name, "_latency"}, n, exp_lat);
      chk({name, "_gnt"}, {28'd0, gnt}, 32'(4'b0001 << widx));
      chk({name, "_prog_sel"}, {30'd0, prog_sel}, widx);
      chk({name, "_run_select"}, {31'd0, run_select}, 32'd1);
   endtask

   task automatic finish_run(input int widx, input int more, input logic err,
                             input logic [15:0] data);
      logic [NREQ-1:0] g;
      g = 4'b0001 << widx;
      repeat (more) @(negedge clk);
      eng_stop  = 1'b1;
      eng_error = err;
      eng_data  = data;
      exp_q.push_back({g, ~err, data, 1'b0});
      @(negedge clk);
      eng_stop  = 1'b0;
      eng_error = 1'b0;
      eng_data  = '0;
      chk("report_gnt_held", {28'd0, gnt}, {28'd0, g});
   endtask

   task automatic chk_reset_values(input string name);
      chk({name, "_gnt"}, {28'd0, gnt}, 32'd0);
      chk({name, "_done"}, {28'd0, done}, 32'd0);
      chk({name, "_pass"}, {31'd0, pass}, 32'd0);
      chk({name, "_fail_pc"}, {16'd0, fail_pc}, 32'd0);
      chk({name, "_busy"}, {31'd0, busy}, 32'd0);
      chk({name, "_timeout"}, {31'd0, timeout}, 32'd0);
      chk({name, "_run_select"}, {31'd0, run_select}, 32'd0);
      chk({name, "_prog_sel"}, {30'd0, prog_sel}, 32'd0);
      chk({name, "_state"}, {30'd0, state_dbg}, 32'd0);
   endtask

   initial begin
      int bad;
      repeat (2) @(negedge clk);
      chk_reset_values("reset");
      rst_n = 1'b1;

      // round robin from reset: 0,1,2,3,0 with 5-cycle runs, 1 IDLE cycle between
      req = 4'b1111;
      wait_grant(0, 1, "rr0");
      finish_run(0, 4, 1'b0, 16'hFFFF);
      for (int k = 1; k <= 4; k++) begin
         wait_grant(k % 4, 2, $sformatf("rr%0d", k));
         finish_run(k % 4, 4, 1'b0, 16'hFFFF);
      end
      req = '0;
      @(negedge clk);

      // single requester, 20-cycle passing run
      req = 4'b0100;
      wait_grant(2, 1, "single");
      finish_run(2, 19, 1'b0, 16'hFFFF);
      chk("single_busy_in_report", {31'd0, busy}, 32'd1);
      req = '0;
      @(negedge clk);

      // failure capture
      req = 4'b0010;
      wait_grant(1, 1, "fail");
      finish_run(1, 2, 1'b1, 16'h002A);
      req = '0;
      @(negedge clk);

      // reset in the middle of a run, then priority restarts at 0
      req = 4'b0100;
      wait_grant(2, 1, "pre_reset");
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      chk_reset_values("mid_reset");
      rst_n = 1'b1;
      req = 4'b1111;
      wait_grant(0, 1, "post_reset");
      finish_run(0, 1, 1'b0, 16'hFFFF);
      req = '0;
      @(negedge clk);

      // abort coincident with eng_stop: no report, same winner afterwards
      req = 4'b1010;
      wait_grant(1, 1, "pre_abort");
      @(negedge clk);
      abort     = 1'b1;
      eng_stop  = 1'b1;
      eng_error = 1'b1;
      eng_data  = 16'h1234;
      @(negedge clk);
      abort     = 1'b0;
      eng_stop  = 1'b0;
      eng_error = 1'b0;
      eng_data  = '0;
      chk("abort_gnt", {28'd0, gnt}, 32'd0);
      chk("abort_done", {28'd0, done}, 32'd0);
      chk("abort_run_select", {31'd0, run_select}, 32'd0);
      chk("abort_state", {30'd0, state_dbg}, 32'd0);
      wait_grant(1, 1, "post_abort");
      finish_run(1, 0, 1'b0, 16'hFFFF);
      req = '0;
      @(negedge clk);

      // withdrawal during RUN is ignored; a one-cycle req[3] pulse is never granted
      req = 4'b0100;
      wait_grant(2, 1, "withdraw");
      @(negedge clk);
      @(negedge clk);
      req = 4'b1000;
      @(negedge clk);
      req = 4'b0000;
      finish_run(2, 2, 1'b1, 16'h0005);
      bad = 0;
      repeat (6) begin
         @(negedge clk);
         if (gnt !== '0) bad++;
      end
      chk("pulsed_req_never_granted", bad, 0);

      // watchdog
      req = 4'b0001;
      wait_grant(0, 1, "wdog");
`ifdef BIST_SCHED_TIMEOUT_EN
      exp_q.push_back({4'b0001, 1'b0, 16'hFFFE, 1'b1});
      repeat (15) @(negedge clk);
      chk("wdog_still_running", {31'd0, run_select}, 32'd1);
      chk("wdog_no_early_done", {28'd0, done}, 32'd0);
      @(negedge clk);
      chk("wdog_report_state", {30'd0, state_dbg}, 32'd2);
      req = '0;
      @(negedge clk);
`else
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (done !== '0 || timeout !== 1'b0 || run_select !== 1'b1) bad++;
      end
      chk("no_watchdog_waits", bad, 0);
      abort = 1'b1;
      req   = '0;
      @(negedge clk);
      abort = 1'b0;
      chk("no_watchdog_abort_gnt", {28'd0, gnt}, 32'd0);
`endif

      repeat (3) @(negedge clk);
      chk("exp_q_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
